readout_deserializer: RTL and testbench

//   Multi-lane serial-to-parallel frame assembler for the fast readout path.

---
 rtl/readout_deserializer.sv | 48 ++++
 tb/tb_readout_deserializer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/readout_deserializer.sv
// readout_deserializer: multi-lane serial-to-parallel frame assembler with a valid/ready holding register
module readout_deserializer #(
  parameter int WIDTH = 512,
  parameter int LANES = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             shift_en,
  input  logic [LANES-1:0]                 shift_in,
  input  logic                             frame_start,
  output logic [WIDTH-1:0]                 data_out,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             overrun,
  input  logic                             clear_overrun,
  output logic [$clog2(WIDTH/LANES)-1:0]   beat_count
);
  localparam int BEATS = WIDTH / LANES;
  localparam int CW = $clog2(BEATS);
  logic [WIDTH-1:0] sreg, base, shifted;
  logic [CW-1:0] base_cnt;
  logic last, accept, drop;
  // frame_start re-aligns before the same-cycle beat, so that beat becomes beat 0
  always_comb begin
    base = frame_start ? '0 : sreg;
    base_cnt = frame_start ? '0 : beat_count;
    shifted = (MSB_FIRST != 0) ? {base[WIDTH-LANES-1:0], shift_in} : {shift_in, base[WIDTH-1:LANES]};
    last = shift_en && (base_cnt == CW'(BEATS - 1));
    accept = last && (!out_valid || out_ready);
    drop = last && out_valid && !out_ready;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg <= '0;
      beat_count <= '0;
      data_out <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sreg <= shift_en ? (last ? '0 : shifted) : base;
      beat_count <= shift_en ? (last ? '0 : base_cnt + 1'b1) : base_cnt;
      data_out <= accept ? shifted : data_out;
      out_valid <= accept || (out_valid && !out_ready);
      overrun <= drop || (overrun && !clear_overrun);
    end
  end
endmodule

// File: tb/tb_readout_deserializer.sv
// tb_readout_deserializer: scoreboard bench driving an MSB-first and an LSB-first 8-bit/2-lane instance in parallel
module tb_readout_deserializer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic shift_en = 1'b0;
  logic frame_start = 1'b0;
  logic out_ready = 1'b0;
  logic clear_overrun = 1'b0;
  logic [1:0] shift_in = 2'b00;
  logic [7:0] dm, dl;
  logic vm, vl, om, ol;
  logic [1:0] cm, cl;
  int tests = 0;
  int fails = 0;
  logic [7:0] qm[$];
  logic [7:0] ql[$];
  logic [7:0] mm = 8'h00;
  logic [7:0] ml = 8'h00;
  int mcnt = 0;
  bit mvalid = 1'b0;
  bit mov = 1'b0;

  always #5 clk = ~clk;

  readout_deserializer #(.WIDTH(8), .LANES(2), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset_n(reset_n), .shift_en(shift_en), .shift_in(shift_in),
    .frame_start(frame_start), .data_out(dm), .out_valid(vm), .out_ready(out_ready),
    .overrun(om), .clear_overrun(clear_overrun), .beat_count(cm));

  readout_deserializer #(.WIDTH(8), .LANES(2), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset_n(reset_n), .shift_en(shift_en), .shift_in(shift_in),
    .frame_start(frame_start), .data_out(dl), .out_valid(vl), .out_ready(out_ready),
    .overrun(ol), .clear_overrun(clear_overrun), .beat_count(cl));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // compare at the falling edge, then advance the model over the coming rising edge
  task automatic tick();
    bit last, accept;
    @(negedge clk);
    chk("valid_m", {31'd0, vm}, {31'd0, mvalid});
    chk("valid_l", {31'd0, vl}, {31'd0, mvalid});
    chk("count_m", {30'd0, cm}, mcnt);
    chk("count_l", {30'd0, cl}, mcnt);
    chk("overrun_m", {31'd0, om}, {31'd0, mov});
    chk("overrun_l", {31'd0, ol}, {31'd0, mov});
    if (mvalid && qm.size() > 0) begin
      chk("data_m", {24'd0, dm}, {24'd0, qm[0]});
      chk("data_l", {24'd0, dl}, {24'd0, ql[0]});
    end
    last = 1'b0;
    if (frame_start) begin
      mm = 8'h00;
      ml = 8'h00;
      mcnt = 0;
    end
    if (shift_en) begin
      mm = {mm[5:0], shift_in};
      ml = {shift_in, ml[7:2]};
      mcnt++;
      last = (mcnt == 4);
    end
    accept = last && (!mvalid || out_ready);
    if (last && !accept) mov = 1'b1;
    else if (clear_overrun) mov = 1'b0;
    if (mvalid && out_ready) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
      mvalid = 1'b0;
    end
    if (accept) begin
      qm.push_back(mm);
      ql.push_back(ml);
      mvalid = 1'b1;
    end
    if (last) begin
      mm = 8'h00;
      ml = 8'h00;
      mcnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] d);
    shift_en = 1'b1;
    shift_in = d;
    tick();
    shift_en = 1'b0;
  endtask

  task automatic frame(input logic [7:0] w);
    for (int i = 3; i >= 0; i--) beat(w[2*i +: 2]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data_m"}, {24'd0, dm}, 32'd0);
    chk({tag, "_data_l"}, {24'd0, dl}, 32'd0);
    chk({tag, "_valid"}, {30'd0, vm, vl}, 32'd0);
    chk({tag, "_overrun"}, {30'd0, om, ol}, 32'd0);
    chk({tag, "_count"}, {28'd0, cm, cl}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    // 1: MSB-first B1, LSB-first 4E, one-cycle valid
    out_ready = 1'b1;
    frame(8'hB1);
    chk("t1_data_m", {24'd0, dm}, 32'hB1);
    chk("t1_data_l", {24'd0, dl}, 32'h4E);
    chk("t1_valid_hi", {31'd0, vm}, 32'd1);
    tick();
    chk("t1_valid_lo", {31'd0, vm}, 32'd0);
    // 3: overrun keeps frame 1, clear_overrun drops the flag
    out_ready = 1'b0;
    frame(8'hB1);
    frame(8'h1B);
    chk("t3_overrun", {31'd0, om}, 32'd1);
    chk("t3_kept", {24'd0, dm}, 32'hB1);
    repeat (2) tick();
    chk("t3_sticky", {31'd0, ol}, 32'd1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("t3_cleared", {31'd0, om}, 32'd0);
    out_ready = 1'b1;
    tick();
    // 4: back-to-back frames, then transfer coinciding with completion
    frame(8'h6C);
    frame(8'hF4);
    tick();
    out_ready = 1'b0;
    frame(8'h39);
    beat(2'b10);
    beat(2'b01);
    beat(2'b11);
    out_ready = 1'b1;
    beat(2'b00);
    chk("t4_valid_kept", {31'd0, vm}, 32'd1);
    chk("t4_new_m", {24'd0, dm}, 32'h9C);
    chk("t4_no_overrun", {31'd0, om}, 32'd0);
    tick();
    // 5: frame_start with a beat re-aligns to beat 0
    beat(2'b01);
    beat(2'b10);
    beat(2'b11);
    frame_start = 1'b1;
    beat(2'b11);
    frame_start = 1'b0;
    chk("t5_count", {30'd0, cm}, 32'd1);
    beat(2'b00);
    beat(2'b00);
    beat(2'b00);
    chk("t5_data_m", {24'd0, dm}, 32'hC0);
    chk("t5_data_l", {24'd0, dl}, 32'h03);
    tick();
    // 6: asynchronous reset mid-frame with a held frame
    out_ready = 1'b0;
    frame(8'h55);
    beat(2'b10);
    beat(2'b10);
    chk("t6_pre_count", {30'd0, cm}, 32'd2);
    chk("t6_pre_valid", {31'd0, vm}, 32'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("t6_async");
    mm = 8'h00;
    ml = 8'h00;
    mcnt = 0;
    mvalid = 1'b0;
    mov = 1'b0;
    qm.delete();
    ql.delete();
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    frame(8'hCC);
    chk("t6_after_m", {24'd0, dm}, 32'hCC);
    chk("t6_after_l", {24'd0, dl}, 32'h33);
    tick();
    // randomized traffic against the model
    for (int i = 0; i < 80; i++) begin
      shift_en = ($urandom_range(0, 3) != 0);
      shift_in = 2'($urandom_range(0, 3));
      frame_start = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear_overrun = ($urandom_range(0, 7) == 0);
      tick();
    end
    shift_en = 1'b0;
    frame_start = 1'b0;
    clear_overrun = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
